hv_abist_seq: RTL

//  Parametrised HV analog BIST sequencer for the HV die. Runs ITEM_NUM analog

---
 rtl/hv_abist_seq_pkg.sv | 26 ++
 rtl/hv_abist_seq_if.sv | 69 ++++++
 rtl/hv_adc_win_chk.sv | 32 +++
 rtl/hv_abist_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hv_abist_seq_pkg.sv
// ---------------------------------------------------------------------------
// hv_abist_pkg
// Shared types and constants for the HV analog BIST sequencer.
//   abist_st_e       : sequencer FSM state encoding
//   CLK_M            : system clock frequency in MHz, used to derive the
//                      default timeout values below
//   DEF_STIM_TMO     : default stimulus window (70 us)
//   DEF_REL_TMO_MIN  : shortest sensible release wait (1 us)
//   DEF_REL_TMO      : default release wait (4 us)
// ---------------------------------------------------------------------------
package hv_abist_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        STIM = 3'd2,
        REL  = 3'd3,
        DONE = 3'd4
    } abist_st_e;

    localparam int CLK_M           = 16;
    localparam int DEF_STIM_TMO    = 70 * CLK_M;
    localparam int DEF_REL_TMO_MIN = 1 * CLK_M;
    localparam int DEF_REL_TMO     = 4 * CLK_M;

endpackage

// File: rtl/hv_abist_seq_if.sv
// ---------------------------------------------------------------------------
// hv_abist_seq_if
// Bundles the control, configuration, analog-response and result signals of
// the HV analog BIST sequencer.
//   slave  modport : the sequencer (inputs i_*, outputs o_*)
//   master modport : whoever drives the sequencer (system controller / bench)
// Signals:
//   i_bist_en      level enable; low aborts a running sequence
//   i_item_mask    1 = skip item
//   i_stim_tmo     per-item STIM window length, item k at [k*CNT_W +: CNT_W]
//   i_rel_tmo      per-item max release wait, same packing
//   i_flt          fault/response flags of analog items 0..ITEM_NUM-2
//   i_adc_data     ADC samples, channel c at [c*ADC_DW +: ADC_DW]
//   i_adc_lo/hi    inclusive ADC window bounds
//   o_bist_stim    one-hot stimulus to the analog block
//   o_bist_status  1 = item not passed
//   o_rel_err      1 = fault did not release in time
//   o_cur_item     active item index, ITEM_NUM when done
//   o_busy         sequence running
//   o_lbist_en     hand-off to logic BIST
//   o_dbg_state    current FSM state
//
// Handshake: there is no valid/ready pair. i_bist_en is a level request that
// must stay high for the whole run; o_busy is high while the request is being
// served and o_lbist_en rises once it has completed. Dropping i_bist_en at any
// time withdraws the request and the sequencer returns to IDLE on the next
// edge. Mask and timeout inputs must be static while o_busy is high.
// ---------------------------------------------------------------------------
interface hv_abist_seq_if #(
    parameter int ITEM_NUM = 6,
    parameter int CNT_W    = 12,
    parameter int ADC_DW   = 10,
    parameter int ADC_CH   = 2
);
    import hv_abist_pkg::*;

    localparam int SEL_W = $clog2(ITEM_NUM + 1);

    logic                       i_bist_en;
    logic [ITEM_NUM-1:0]        i_item_mask;
    logic [ITEM_NUM*CNT_W-1:0]  i_stim_tmo;
    logic [ITEM_NUM*CNT_W-1:0]  i_rel_tmo;
    logic [ITEM_NUM-2:0]        i_flt;
    logic [ADC_CH*ADC_DW-1:0]   i_adc_data;
    logic [ADC_DW-1:0]          i_adc_lo;
    logic [ADC_DW-1:0]          i_adc_hi;
    logic [ITEM_NUM-1:0]        o_bist_stim;
    logic [ITEM_NUM-1:0]        o_bist_status;
    logic [ITEM_NUM-1:0]        o_rel_err;
    logic [SEL_W-1:0]           o_cur_item;
    logic                       o_busy;
    logic                       o_lbist_en;
    abist_st_e                  o_dbg_state;

    modport slave (
        input  i_bist_en, i_item_mask, i_stim_tmo, i_rel_tmo, i_flt,
               i_adc_data, i_adc_lo, i_adc_hi,
        output o_bist_stim, o_bist_status, o_rel_err, o_cur_item,
               o_busy, o_lbist_en, o_dbg_state
    );

    modport master (
        output i_bist_en, i_item_mask, i_stim_tmo, i_rel_tmo, i_flt,
               i_adc_data, i_adc_lo, i_adc_hi,
        input  o_bist_stim, o_bist_status, o_rel_err, o_cur_item,
               o_busy, o_lbist_en, o_dbg_state
    );

endinterface

// File: rtl/hv_adc_win_chk.sv
// ---------------------------------------------------------------------------
// hv_adc_win_chk
// Combinational multi-channel ADC window compare.
//   i_adc_data : ADC_CH samples, channel c at [c*ADC_DW +: ADC_DW]
//   i_adc_lo   : inclusive lower bound (unsigned)
//   i_adc_hi   : inclusive upper bound (unsigned)
//   o_adc_ok   : 1 when every channel lies inside [lo, hi]
// ---------------------------------------------------------------------------
module hv_adc_win_chk #(
    parameter int ADC_DW = 10,
    parameter int ADC_CH = 2
) (
    input  logic [ADC_CH*ADC_DW-1:0] i_adc_data,
    input  logic [ADC_DW-1:0]        i_adc_lo,
    input  logic [ADC_DW-1:0]        i_adc_hi,
    output logic                     o_adc_ok
);

    logic [ADC_DW-1:0] sample;

    always_comb begin
        o_adc_ok = 1'b1;
        sample   = '0;
        for (int c = 0; c < ADC_CH; c++) begin
            sample = i_adc_data[c*ADC_DW +: ADC_DW];
            if ((sample < i_adc_lo) || (sample > i_adc_hi)) begin
                o_adc_ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hv_abist_seq.sv
// ---------------------------------------------------------------------------
// hv_abist_seq
// HV analog BIST sequencer. Walks the ITEM_NUM self-test items in index
// order; for each unmasked item it drives a stimulus window, records whether
// the item responded, then waits for the response to release. Items that
// never respond are re-stimulated up to RETRY_NUM extra times. The last item
// is the ADC window check, whose response is the combinational adc_ok.
// When every item has been visited, the sequencer parks in DONE and hands
// off to logic BIST.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      hv_abist_seq_if slave modport (enable, mask, timeouts,
//            analog flags, ADC samples in; stimulus, status, errors,
//            progress, busy, lbist hand-off and FSM state out)
// ---------------------------------------------------------------------------
module hv_abist_seq
    import hv_abist_pkg::*;
#(
    parameter int ITEM_NUM  = 6,
    parameter int CNT_W     = 12,
    parameter int ADC_DW    = 10,
    parameter int ADC_CH    = 2,
    parameter int RETRY_NUM = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    hv_abist_seq_if.slave bus
);

    localparam int SEL_W = $clog2(ITEM_NUM + 1);
    localparam int IDX_W = (ITEM_NUM > 1) ? $clog2(ITEM_NUM) : 1;
    localparam int RTY_W = (RETRY_NUM > 0) ? $clog2(RETRY_NUM + 1) : 1;

    localparam logic [SEL_W-1:0] SEL_END  = SEL_W'(ITEM_NUM);
    localparam logic [SEL_W-1:0] SEL_ADC  = SEL_W'(ITEM_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    abist_st_e           state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic [ITEM_NUM-1:0] status_q, status_d;
    logic [ITEM_NUM-1:0] rel_err_q, rel_err_d;
    logic [ITEM_NUM-1:0] stim_q, stim_d;
    logic                lbist_q, lbist_d;

    // ---------------------------------------------------------------------
    // Datapath helpers
    // ---------------------------------------------------------------------
    logic                adc_ok;
    logic [ITEM_NUM-1:0] det;
    logic [IDX_W-1:0]    idx;
    logic                det_cur;
    logic                is_adc;
    logic [CNT_W-1:0]    stim_tmo_a [ITEM_NUM];
    logic [CNT_W-1:0]    rel_tmo_a  [ITEM_NUM];
    logic [CNT_W-1:0]    stim_last;
    logic [CNT_W-1:0]    rel_last;
    logic [CNT_W-1:0]    cnt_inc;
    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;
    logic                rel_exit;
    logic                retry_ok;

    hv_adc_win_chk #(
        .ADC_DW (ADC_DW),
        .ADC_CH (ADC_CH)
    ) u_adc_win_chk (
        .i_adc_data (bus.i_adc_data),
        .i_adc_lo   (bus.i_adc_lo),
        .i_adc_hi   (bus.i_adc_hi),
        .o_adc_ok   (adc_ok)
    );

    for (genvar k = 0; k < ITEM_NUM; k++) begin : g_unpack
        assign stim_tmo_a[k] = bus.i_stim_tmo[k*CNT_W +: CNT_W];
        assign rel_tmo_a[k]  = bus.i_rel_tmo[k*CNT_W +: CNT_W];
    end

    assign det     = {adc_ok, bus.i_flt};
    assign idx     = sel_q[IDX_W-1:0];
    assign det_cur = det[idx];
    assign is_adc  = (sel_q == SEL_ADC);

    // Last counter value of each window. A programmed 0 behaves like 1, so
    // both 0 and 1 give a last value of 0 (a single-cycle window).
    assign stim_last = (stim_tmo_a[idx] == '0) ? '0 : stim_tmo_a[idx] - 1'b1;
    assign rel_last  = (rel_tmo_a[idx]  == '0) ? '0 : rel_tmo_a[idx]  - 1'b1;

    // Saturating increment: the counter never wraps back to 0.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    assign retry_ok = (int'(retry_q) < RETRY_NUM);

    // Lowest unmasked item at or above sel. Scanning downward lets the
    // lowest qualifying index overwrite the others, so the whole skip over
    // masked items happens in one SEL cycle.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = SEL_END;
        for (int k = ITEM_NUM - 1; k >= 0; k--) begin
            if (!bus.i_item_mask[k] && (SEL_W'(k) >= sel_q)) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(k);
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        status_d  = status_q;
        rel_err_d = rel_err_q;
        rel_exit  = 1'b0;

        if (!bus.i_bist_en) begin
            // Abort from any state. Status and rel_err are kept; only the
            // walk position is rewound so a new enable starts at item 0.
            state_d = IDLE;
            sel_d   = '0;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SEL;
                end

                SEL: begin
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        cnt_d   = '0;
                        state_d = STIM;
                    end else begin
                        sel_d   = SEL_END;
                        state_d = DONE;
                    end
                end

                STIM: begin
                    if (det_cur) begin
                        status_d[idx] = 1'b0;
                    end
                    if (cnt_q == stim_last) begin
                        cnt_d   = '0;
                        state_d = REL;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                REL: begin
                    // The ADC check has nothing to release, so it leaves
                    // after one cycle and can never raise rel_err.
                    if (is_adc || !det_cur) begin
                        rel_exit = 1'b1;
                    end else if (cnt_q == rel_last) begin
                        rel_exit       = 1'b1;
                        rel_err_d[idx] = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end

                    if (rel_exit) begin
                        cnt_d = '0;
                        if (status_q[idx] && retry_ok) begin
                            retry_d = retry_q + 1'b1;
                            state_d = STIM;
                        end else begin
                            retry_d = '0;
                            sel_d   = sel_q + 1'b1;
                            state_d = SEL;
                        end
                    end
                end

                DONE: begin
                    state_d = DONE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Stimulus and hand-off flops follow the current state one cycle later;
    // gating with the enable makes both drop on the edge right after abort.
    always_comb begin
        stim_d = '0;
        if ((state_q == STIM) && bus.i_bist_en) begin
            stim_d[idx] = 1'b1;
        end
        lbist_d = (state_q == DONE) && bus.i_bist_en;
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            retry_q   <= '0;
            status_q  <= '1;
            rel_err_q <= '0;
            stim_q    <= '0;
            lbist_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            status_q  <= status_d;
            rel_err_q <= rel_err_d;
            stim_q    <= stim_d;
            lbist_q   <= lbist_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.o_bist_stim   = stim_q;
    assign bus.o_bist_status = status_q;
    assign bus.o_rel_err     = rel_err_q;
    assign bus.o_cur_item    = sel_q;
    assign bus.o_busy        = (state_q != IDLE) && (state_q != DONE);
    assign bus.o_lbist_en    = lbist_q;
    assign bus.o_dbg_state   = state_q;

endmodule
